bs_gnrtr_n_rbtr: RTL and testbench
==================================

BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 Parameter bits, default 1, SHALL set the number of independent bus channels.
REQ-002 Parameter drvrs, default 4, SHALL set the number of devices attached to each channel.
REQ-003 Parameter pckg_sz, default 16, SHALL set the packet width in bits; minimum 9.
REQ-004 Parameter broadcast, default 8'hFF, SHALL set the 8-bit destination ID meaning "all devices".
REQ-005 Port clk: input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 Port reset: input, 1 bit, asynchronous and active-high.
REQ-007 Port pndng: input, [bits-1:0][drvrs-1:0], device FIFO non-empty flag.
REQ-008 Port D_pop: input, [bits-1:0][drvrs-1:0][pckg_sz-1:0], head-of-FIFO packet per device.
REQ-009 Port pop: output, [bits-1:0][drvrs-1:0], one-cycle dequeue strobe to a device.
REQ-010 Port push: output, [bits-1:0][drvrs-1:0], one-cycle enqueue strobe to a device.
REQ-011 Port D_push: output, [bits-1:0][drvrs-1:0][pckg_sz-1:0], bus packet delivered to every device.

Function
REQ-012 Each channel b SHALL arbitrate and transfer independently of the other channels.
REQ-013 Packet fields: destination ID = D_pop[pckg_sz-1 -: 8]; payload = the remaining low bits.
REQ-014 The per-channel FSM SHALL have states IDLE, POP and PUSH, all outputs registered.
REQ-015 IDLE with no pndng bit set: SHALL stay in IDLE with pop and push all 0.
REQ-016 IDLE with any pndng bit set, at the clock edge:
  - grant the first requester searching round-robin from last_grant+1 (mod drvrs);
  - latch the granted device's D_pop into the bus register;
  - go to POP.
REQ-017 POP: pop[grant]=1 for exactly one cycle, all other pop bits 0; next state PUSH.
REQ-018 PUSH:
  - every D_push[b][i] SHALL equal the latched packet;
  - push[dest]=1 for exactly one cycle when dest<drvrs;
  - next state IDLE; last_grant<=grant.
REQ-019 When dest==broadcast, push SHALL be 1 for every device except the source, in the same cycle.
REQ-020 A destination that is neither <drvrs nor broadcast SHALL still be popped, then dropped: no push bit asserted.
REQ-021 A packet whose dest equals its source (unicast) SHALL be pushed back to the source.
REQ-022 D_push SHALL hold the last transferred packet outside PUSH.
REQ-023 Throughput SHALL be one packet per 3 cycles per channel, with pndng re-sampled in IDLE after the pop.
REQ-024 A pndng change during POP or PUSH SHALL NOT alter the transfer in progress.

Reset
REQ-025 Assertion of reset SHALL immediately force, asynchronously:
  - state=IDLE;
  - pop=0, push=0, D_push=0;
  - last_grant=drvrs-1, so that the first grant goes to device 0.
REQ-026 Reset during POP or PUSH SHALL abort the transfer with no further strobes; a packet popped but not pushed is lost.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the 8-bit ID width constant and the default broadcast value.
REQ-028 One sub-module, bus_channel, SHALL implement a single channel's arbiter, FSM and datapath; the top SHALL generate bits instances of it.

Verification (drvrs=4, pckg_sz=16, bits=1)
REQ-029 Reset asserted -> pop=0, push=0, D_push=0 in the same cycle, without waiting for a clock edge.
REQ-030 pndng[1]=1 with D_pop[1]=16'h0234 -> pop[1] pulses one cycle, then push[2] pulses one cycle, then D_push[*]=16'h0234.
REQ-031 pndng[0]=1 with D_pop[0]=16'hFFAA -> push=4'b1110 for one cycle, then D_push[*]=16'hFFAA.
REQ-032 All four pndng held high -> pop grants in order 0,1,2,3,0, one grant every 3 cycles.
REQ-033 D_pop[3]=16'h07C1 pending -> pop[3] pulses and push stays 4'b0000.
REQ-034 Reset pulsed while in POP -> pop drops immediately, no push follows, and the next grant goes to device 0.

Source files
------------

// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// bs_gnrtr_n_rbtr_pkg: FSM state encoding and destination-ID constants shared by the bus arbiter.
package bs_gnrtr_n_rbtr_pkg;
    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;
    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_DFLT = 8'hFF;
endpackage

// File: rtl/bs_gnrtr_n_rbtr_bus_channel.sv
// bus_channel: one bus channel -- round-robin arbiter, IDLE/POP/PUSH FSM and packet datapath.
module bus_channel
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int drvrs = 4,
    parameter int pckg_sz = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_DFLT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);
    localparam int GW = drvrs > 1 ? $clog2(drvrs) : 1;
    state_t r_state;
    logic [GW-1:0] r_last, r_gnt, w_gnt, w_idx;
    logic [pckg_sz-1:0] r_bus, r_dpush;
    logic [drvrs-1:0] r_pop, r_push, w_mask;
    logic [ID_W-1:0] w_dest;
    // Scan downward so the requester closest after r_last is the one left in w_gnt.
    always_comb begin
        w_gnt = r_last;
        w_idx = '0;
        for (int k = drvrs; k >= 1; k--) begin
            w_idx = GW'((int'(r_last) + k) % drvrs);
            if (pndng[w_idx]) w_gnt = w_idx;
        end
    end
    assign w_dest = r_bus[pckg_sz-1 -: ID_W];
    assign w_mask = (w_dest == broadcast) ? ~(drvrs'(1) << r_gnt) :
                    (int'(w_dest) < drvrs) ? drvrs'(1) << w_dest : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= GW'(drvrs - 1);
            r_gnt   <= '0;
            r_bus   <= '0;
            r_dpush <= '0;
            r_pop   <= '0;
            r_push  <= '0;
        end else begin
            case (r_state)
                IDLE: if (|pndng) begin
                    r_gnt   <= w_gnt;
                    r_bus   <= D_pop[w_gnt];
                    r_pop   <= drvrs'(1) << w_gnt;
                    r_state <= POP;
                end
                POP: begin
                    r_pop   <= '0;
                    r_push  <= w_mask;
                    r_dpush <= r_bus;
                    r_state <= PUSH;
                end
                default: begin
                    r_push  <= '0;
                    r_last  <= r_gnt;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign pop    = r_pop;
    assign push   = r_push;
    assign D_push = {drvrs{r_dpush}};
endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// bs_gnrtr_n_rbtr: bus generator and arbiter -- one independent bus_channel per bit lane.
module bs_gnrtr_n_rbtr
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int bits = 1,
    parameter int drvrs = 4,
    parameter int pckg_sz = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_DFLT
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);
    for (genvar g = 0; g < bits; g++) begin : g_ch
        bus_channel #(
            .drvrs(drvrs),
            .pckg_sz(pckg_sz),
            .broadcast(broadcast)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .pndng(pndng[g]),
            .D_pop(D_pop[g]),
            .pop(pop[g]),
            .push(push[g]),
            .D_push(D_push[g])
        );
    end
endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// tb_bs_gnrtr_n_rbtr: vector table, reset/round-robin sequences and randomized model check of the bus arbiter.
module tb_bs_gnrtr_n_rbtr;
    localparam int D = 4;
    localparam int P = 16;
    typedef struct packed {
        logic [D-1:0] pn;
        logic [D-1:0][P-1:0] dp;
        logic [D-1:0] epop;
        logic [D-1:0] epush;
        logic [P-1:0] edata;
    } vec_t;
    logic clk = 1'b0;
    logic reset;
    logic [0:0][D-1:0] pndng, pop, push;
    logic [0:0][D-1:0][P-1:0] D_pop, D_push;
    int n_chk = 0;
    int n_pass = 0;
    logic [P-1:0] last_d;
    vec_t tv[7];

    bs_gnrtr_n_rbtr #(.bits(1), .drvrs(D), .pckg_sz(P), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic chk_data(input string nm, input logic [P-1:0] exp);
        for (int i = 0; i < D; i++) chk($sformatf("%s D_push[%0d]", nm, i), 32'(D_push[0][i]), 32'(exp));
    endtask

    // One arbitration window from IDLE: POP cycle, PUSH cycle, back in IDLE.
    task automatic xfer(input string nm, input logic [D-1:0] pn, input logic [D-1:0][P-1:0] dp,
                        input logic [D-1:0] epop, input logic [D-1:0] epush,
                        input logic [P-1:0] edata, input logic [P-1:0] eprev);
        pndng[0] = pn;
        D_pop[0] = dp;
        @(posedge clk); #1;
        chk({nm, " pop"}, 32'(pop[0]), 32'(epop));
        chk({nm, " push@pop"}, 32'(push[0]), 0);
        chk_data({nm, " hold@pop"}, eprev);
        pndng[0] = '0;
        D_pop[0] = ~dp;
        @(posedge clk); #1;
        chk({nm, " pop@push"}, 32'(pop[0]), 0);
        chk({nm, " push"}, 32'(push[0]), 32'(epush));
        chk_data({nm, " data"}, edata);
        @(posedge clk); #1;
        chk({nm, " pop@idle"}, 32'(pop[0]), 0);
        chk({nm, " push@idle"}, 32'(push[0]), 0);
        chk_data({nm, " hold@idle"}, edata);
    endtask

    initial begin
        int last;
        int gnt_q[$];
        int cyc_q[$];
        tv[0] = '{4'b0010, {16'h1111, 16'h2222, 16'h0234, 16'h3333}, 4'b0010, 4'b0100, 16'h0234};
        tv[1] = '{4'b0001, {16'h1111, 16'h2222, 16'h3333, 16'hFFAA}, 4'b0001, 4'b1110, 16'hFFAA};
        tv[2] = '{4'b1000, {16'h07C1, 16'h2222, 16'h3333, 16'h4444}, 4'b1000, 4'b0000, 16'h07C1};
        tv[3] = '{4'b0100, {16'h1111, 16'h0255, 16'h3333, 16'h4444}, 4'b0100, 4'b0100, 16'h0255};
        tv[4] = '{4'b0110, {16'h1111, 16'h0099, 16'h0312, 16'h4444}, 4'b0010, 4'b1000, 16'h0312};
        tv[5] = '{4'b1111, {16'h0011, 16'hFF00, 16'h0022, 16'h0033}, 4'b0100, 4'b1011, 16'hFF00};
        tv[6] = '{4'b0011, {16'h1111, 16'h2222, 16'h3333, 16'h0100}, 4'b0001, 4'b0010, 16'h0100};
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        @(posedge clk); #1;
        chk("reset pop", 32'(pop[0]), 0);
        chk("reset push", 32'(push[0]), 0);
        chk_data("reset", '0);
        reset = 1'b0;
        last_d = '0;
        for (int i = 0; i < 7; i++) begin
            xfer($sformatf("vec%0d", i), tv[i].pn, tv[i].dp, tv[i].epop, tv[i].epush, tv[i].edata, last_d);
            last_d = tv[i].edata;
        end
        // Reset mid-POP: strobes and bus clear at once, nothing is pushed afterwards.
        pndng[0] = 4'b1000;
        D_pop[0] = {16'h0133, 16'h0000, 16'h0000, 16'h0000};
        @(posedge clk); #1;
        chk("abort pre pop", 32'(pop[0]), 32'(4'b1000));
        #2 reset = 1'b1;
        #1;
        chk("abort pop", 32'(pop[0]), 0);
        chk("abort push", 32'(push[0]), 0);
        chk_data("abort", '0);
        @(posedge clk); #1;
        chk("abort push after edge", 32'(push[0]), 0);
        #2 reset = 1'b0;
        pndng[0] = 4'b1111;
        D_pop[0] = {16'h0000, 16'h0001, 16'h0002, 16'h0003};
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < D; i++) if (pop[0][i]) begin gnt_q.push_back(i); cyc_q.push_back(c); end
        end
        pndng[0] = '0;
        chk("rr grant count", 32'(gnt_q.size()), 5);
        for (int i = 0; i < 5 && i < gnt_q.size(); i++) begin
            chk($sformatf("rr grant %0d", i), 32'(gnt_q[i]), 32'(i % D));
            chk($sformatf("rr cycle %0d", i), 32'(cyc_q[i]), 32'(3 * i));
        end
        last_d = 16'h0003;
        last = 0;
        // Randomized transfers against the arbitration rules.
        for (int t = 0; t < 80; t++) begin
            logic [D-1:0] pn, epop, epush;
            logic [D-1:0][P-1:0] dp;
            logic [P-1:0] ed;
            logic [7:0] dest;
            int g;
            pn = D'($urandom);
            for (int i = 0; i < D; i++) begin
                int r;
                r = $urandom_range(0, 5);
                dest = r < 4 ? 8'(r) : r == 4 ? 8'hFF : 8'($urandom_range(4, 254));
                dp[i] = {dest, 8'($urandom)};
            end
            g = -1;
            for (int k = 1; k <= D; k++) if (g < 0 && pn[(last + k) % D]) g = (last + k) % D;
            if (g < 0) begin
                epop = '0;
                epush = '0;
                ed = last_d;
            end else begin
                dest = dp[g][P-1 -: 8];
                epop = '0;
                epop[g] = 1'b1;
                epush = '0;
                if (dest == 8'hFF) begin
                    epush = '1;
                    epush[g] = 1'b0;
                end else if (dest < D) epush[dest] = 1'b1;
                ed = dp[g];
                last = g;
            end
            xfer($sformatf("rnd%0d", t), pn, dp, epop, epush, ed, last_d);
            last_d = ed;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
